// File: rtl/wb_pkg.sv
// Shared types and constants for the writeback write-port scheduler.
// Holds the datapath widths, the mux-select encodings and the queued-result entry type.
package wb_pkg;

    localparam int XLEN = 32;
    localparam int AW   = 5;

    localparam logic MEM_TO_REG_ALU = 1'b0;
    localparam logic MEM_TO_REG_LD  = 1'b1;

    typedef struct packed {
        logic [AW-1:0]   rd;
        logic [XLEN-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_result_fifo.sv
// DEPTH-entry synchronous FIFO of wb_entry_t buffering ALU results that lost arbitration.
// Ports: clk, rst (sync, active-high), push/din, pop/head, full, empty, count.
module wb_result_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  wb_entry_t                  din,
    input  logic                       pop,
    output wb_entry_t                  head,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PW = $clog2(DEPTH);

    wb_entry_t     mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == (PW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count + (PW+1)'(do_push) - (PW+1)'(do_pop);
        end
    end

endmodule

// File: rtl/wb_port_sched.sv
// Register-file write-port scheduler: loads win, ALU results bypass or queue.
// Ports: clk, rst, alu_valid/rd/data/ready, ld_valid/rd/data, rf_we/wa/wd, mem_to_reg,
// pend_mask, ovf_err; stat_ld_cnt/stat_alu_cnt/stat_stall_cnt when WB_STAT_EN is defined.
module wb_port_sched #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2,
    parameter int AW    = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            alu_valid,
    input  logic [AW-1:0]   alu_rd,
    input  logic [XLEN-1:0] alu_data,
    output logic            alu_ready,
    input  logic            ld_valid,
    input  logic [AW-1:0]   ld_rd,
    input  logic [XLEN-1:0] ld_data,
    output logic            rf_we,
    output logic [AW-1:0]   rf_wa,
    output logic [XLEN-1:0] rf_wd,
    output logic            mem_to_reg,
    output logic [2**AW-1:0] pend_mask,
    output logic            ovf_err
`ifdef WB_STAT_EN
    ,
    output logic [31:0]     stat_ld_cnt,
    output logic [31:0]     stat_alu_cnt,
    output logic [31:0]     stat_stall_cnt
`endif
);

    import wb_pkg::*;

    localparam int CW = $clog2(DEPTH + 2);
    localparam int NR = 2 ** AW;
    localparam int QW = $clog2(DEPTH) + 1;

    wb_entry_t     alu_entry;
    wb_entry_t     head;
    logic          full;
    logic          empty;
    logic [QW-1:0] count;
    logic          ld_iss;
    logic          alu_acc;
    logic          pop;
    logic          bypass;
    logic          push;
    logic [NR-1:0] queued;

    assign alu_ready = !full;
    assign ld_iss    = ld_valid && (ld_rd != '0);
    assign alu_acc   = alu_valid && alu_ready && (alu_rd != '0);
    assign pop       = !ld_iss && !empty;
    assign bypass    = !ld_iss && (count == '0) && alu_acc;
    assign push      = alu_acc && !bypass;
    assign alu_entry = '{rd: alu_rd, data: alu_data};

    wb_result_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (alu_entry),
        .pop   (pop),
        .head  (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            rf_we      <= 1'b0;
            rf_wa      <= '0;
            rf_wd      <= '0;
            mem_to_reg <= MEM_TO_REG_ALU;
        end else if (ld_iss) begin
            rf_we      <= 1'b1;
            rf_wa      <= ld_rd;
            rf_wd      <= ld_data;
            mem_to_reg <= MEM_TO_REG_LD;
        end else if (pop) begin
            rf_we      <= 1'b1;
            rf_wa      <= head.rd;
            rf_wd      <= head.data;
            mem_to_reg <= MEM_TO_REG_ALU;
        end else if (bypass) begin
            rf_we      <= 1'b1;
            rf_wa      <= alu_rd;
            rf_wd      <= alu_data;
            mem_to_reg <= MEM_TO_REG_ALU;
        end else begin
            rf_we      <= 1'b0;
        end
    end

    // Each counter holds FIFO entries for r plus the output register if it targets r.
    // A pop just moves an entry into the output register, so it leaves the count alone.
    for (genvar r = 0; r < NR; r++) begin : g_pend
        logic [CW-1:0] cnt;
        logic          set_push;
        logic          set_cap;
        logic          clr;

        assign set_push = push && (alu_rd == AW'(r));
        assign set_cap  = (ld_iss && (ld_rd == AW'(r)))
                        || (bypass && (alu_rd == AW'(r)));
        assign clr      = rf_we && (rf_wa == AW'(r));

        always_ff @(posedge clk) begin
            if (rst) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CW'(set_push) + CW'(set_cap) - CW'(clr);
            end
        end

        assign pend_mask[r] = (cnt != '0);
        // Excluding the output register leaves only entries still sitting in the FIFO.
        assign queued[r]    = (cnt > CW'(clr));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_err <= 1'b0;
        end else if (ld_iss && queued[ld_rd]) begin
            ovf_err <= 1'b1;
        end
    end

`ifdef WB_STAT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_ld_cnt    <= '0;
            stat_alu_cnt   <= '0;
            stat_stall_cnt <= '0;
        end else begin
            if (ld_iss) begin
                stat_ld_cnt <= stat_ld_cnt + 32'd1;
            end
            if (pop || bypass) begin
                stat_alu_cnt <= stat_alu_cnt + 32'd1;
            end
            if (alu_valid && !alu_ready) begin
                stat_stall_cnt <= stat_stall_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_wb_port_sched.sv
// Self-checking bench for wb_port_sched: directed scenarios plus a randomized run
// against a queue-based reference model of the write-port grant rules.
module tb_wb_port_sched;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        alu_ready;
    logic        ld_valid;
    logic [4:0]  ld_rd;
    logic [31:0] ld_data;
    logic        rf_we;
    logic [4:0]  rf_wa;
    logic [31:0] rf_wd;
    logic        mem_to_reg;
    logic [31:0] pend_mask;
    logic        ovf_err;
`ifdef WB_STAT_EN
    logic [31:0] stat_ld_cnt;
    logic [31:0] stat_alu_cnt;
    logic [31:0] stat_stall_cnt;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    wb_port_sched #(
        .XLEN  (32),
        .DEPTH (DEPTH),
        .AW    (5)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .alu_valid  (alu_valid),
        .alu_rd     (alu_rd),
        .alu_data   (alu_data),
        .alu_ready  (alu_ready),
        .ld_valid   (ld_valid),
        .ld_rd      (ld_rd),
        .ld_data    (ld_data),
        .rf_we      (rf_we),
        .rf_wa      (rf_wa),
        .rf_wd      (rf_wd),
        .mem_to_reg (mem_to_reg),
        .pend_mask  (pend_mask),
        .ovf_err    (ovf_err)
`ifdef WB_STAT_EN
        ,
        .stat_ld_cnt    (stat_ld_cnt),
        .stat_alu_cnt   (stat_alu_cnt),
        .stat_stall_cnt (stat_stall_cnt)
`endif
    );

    // Reference model: pending ALU results in arrival order plus the write register.
    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;

    ent_t        q[$];
    logic        m_we;
    logic [4:0]  m_wa;
    logic [31:0] m_wd;
    logic        m_m2r;
    logic        m_ovf;

    function automatic logic [31:0] pend_model();
        logic [31:0] m = '0;
        foreach (q[i]) m[q[i].rd] = 1'b1;
        if (m_we) m[m_wa] = 1'b1;
        return m;
    endfunction

    task automatic model_edge();
        ent_t e;
        logic acc;
        if (rst) begin
            q.delete();
            m_we = 0; m_wa = 0; m_wd = 0; m_m2r = 0; m_ovf = 0;
            return;
        end
        acc = alu_valid && (q.size() < DEPTH) && (alu_rd != 0);
        e.rd = alu_rd;
        e.data = alu_data;
        if (ld_valid && ld_rd != 0) begin
            foreach (q[i]) if (q[i].rd == ld_rd) m_ovf = 1;
            m_we = 1; m_m2r = 1; m_wa = ld_rd; m_wd = ld_data;
            if (acc) q.push_back(e);
        end else if (q.size() > 0) begin
            ent_t h = q.pop_front();
            m_we = 1; m_m2r = 0; m_wa = h.rd; m_wd = h.data;
            if (acc) q.push_back(e);
        end else if (acc) begin
            m_we = 1; m_m2r = 0; m_wa = alu_rd; m_wd = alu_data;
        end else begin
            m_we = 0;
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle();
        rst = 0; alu_valid = 0; alu_rd = 0; alu_data = 0;
        ld_valid = 0; ld_rd = 0; ld_data = 0;
    endtask

    task automatic test_reset();
        idle();
        rst = 1;
        cyc();
        rst = 0;
        n_cmp++;
        if (rf_we !== 0 || rf_wa !== 0 || rf_wd !== 0 || mem_to_reg !== 0) begin
            n_bad++;
            $display("FAIL reset_out: we=%0b wa=%0d wd=%h m2r=%0b want all 0",
                     rf_we, rf_wa, rf_wd, mem_to_reg);
        end
        n_cmp++;
        if (pend_mask !== 0 || ovf_err !== 0 || alu_ready !== 1) begin
            n_bad++;
            $display("FAIL reset_flags: pend=%h ovf=%0b rdy=%0b want 0/0/1",
                     pend_mask, ovf_err, alu_ready);
        end
    endtask

    task automatic test_lone_alu();
        idle();
        alu_valid = 1; alu_rd = 5; alu_data = 32'h1234;
        n_cmp++;
        if (alu_ready !== 1) begin
            n_bad++; $display("FAIL lone_ready: got %0b want 1", alu_ready);
        end
        cyc();
        idle();
        n_cmp++;
        if (rf_we !== 1 || rf_wa !== 5 || rf_wd !== 32'h1234 || mem_to_reg !== 0) begin
            n_bad++;
            $display("FAIL lone_write: we=%0b wa=%0d wd=%h m2r=%0b want 1/5/1234/0",
                     rf_we, rf_wa, rf_wd, mem_to_reg);
        end
        n_cmp++;
        if (pend_mask !== 32'h20) begin
            n_bad++; $display("FAIL lone_pend: got %h want 00000020", pend_mask);
        end
        cyc();
        n_cmp++;
        if (rf_we !== 0 || pend_mask !== 0) begin
            n_bad++;
            $display("FAIL lone_after: we=%0b pend=%h want 0/0", rf_we, pend_mask);
        end
    endtask

    task automatic test_collision();
        idle();
        ld_valid = 1; ld_rd = 3; ld_data = 32'hAAAA;
        alu_valid = 1; alu_rd = 7; alu_data = 32'hBBBB;
        cyc();
        idle();
        n_cmp++;
        if (rf_we !== 1 || rf_wa !== 3 || rf_wd !== 32'hAAAA || mem_to_reg !== 1) begin
            n_bad++;
            $display("FAIL coll_ld: we=%0b wa=%0d wd=%h m2r=%0b want 1/3/aaaa/1",
                     rf_we, rf_wa, rf_wd, mem_to_reg);
        end
        n_cmp++;
        if (pend_mask !== 32'h88) begin
            n_bad++; $display("FAIL coll_pend1: got %h want 00000088", pend_mask);
        end
        cyc();
        n_cmp++;
        if (rf_we !== 1 || rf_wa !== 7 || rf_wd !== 32'hBBBB || mem_to_reg !== 0) begin
            n_bad++;
            $display("FAIL coll_alu: we=%0b wa=%0d wd=%h m2r=%0b want 1/7/bbbb/0",
                     rf_we, rf_wa, rf_wd, mem_to_reg);
        end
        n_cmp++;
        if (pend_mask !== 32'h80) begin
            n_bad++; $display("FAIL coll_pend2: got %h want 00000080", pend_mask);
        end
        cyc();
        n_cmp++;
        if (rf_we !== 0 || pend_mask !== 0) begin
            n_bad++;
            $display("FAIL coll_after: we=%0b pend=%h want 0/0", rf_we, pend_mask);
        end
    endtask

    task automatic test_backpressure();
        logic [4:0]  exp_rd [2];
        logic [31:0] exp_d  [2];
        exp_rd[0] = 20; exp_rd[1] = 21;
        exp_d[0] = 32'hC000_0014; exp_d[1] = 32'hC000_0015;
        for (int i = 0; i < 4; i++) begin
            idle();
            ld_valid = 1; ld_rd = 5'(10 + i); ld_data = 32'hD000_0000 + i;
            alu_valid = 1; alu_rd = 5'(20 + i); alu_data = 32'hC000_0014 + i;
            n_cmp++;
            if (alu_ready !== (i < 2)) begin
                n_bad++;
                $display("FAIL bp_ready%0d: got %0b want %0b", i, alu_ready, i < 2);
            end
            cyc();
            n_cmp++;
            if (rf_we !== 1 || rf_wa !== 5'(10 + i) || mem_to_reg !== 1) begin
                n_bad++;
                $display("FAIL bp_ld%0d: we=%0b wa=%0d m2r=%0b want 1/%0d/1",
                         i, rf_we, rf_wa, mem_to_reg, 10 + i);
            end
        end
        idle();
        for (int i = 0; i < 2; i++) begin
            cyc();
            n_cmp++;
            if (rf_we !== 1 || rf_wa !== exp_rd[i] || rf_wd !== exp_d[i] || mem_to_reg !== 0) begin
                n_bad++;
                $display("FAIL bp_drain%0d: we=%0b wa=%0d wd=%h m2r=%0b want 1/%0d/%h/0",
                         i, rf_we, rf_wa, rf_wd, mem_to_reg, exp_rd[i], exp_d[i]);
            end
        end
        cyc();
        n_cmp++;
        if (rf_we !== 0 || pend_mask !== 0 || alu_ready !== 1) begin
            n_bad++;
            $display("FAIL bp_end: we=%0b pend=%h rdy=%0b want 0/0/1",
                     rf_we, pend_mask, alu_ready);
        end
    endtask

    task automatic test_x0();
        idle();
        alu_valid = 1; alu_rd = 0; alu_data = 32'h5555;
        ld_valid = 1; ld_rd = 0; ld_data = 32'h6666;
        n_cmp++;
        if (alu_ready !== 1) begin
            n_bad++; $display("FAIL x0_ready: got %0b want 1", alu_ready);
        end
        cyc();
        idle();
        n_cmp++;
        if (rf_we !== 0 || pend_mask !== 0) begin
            n_bad++;
            $display("FAIL x0_write: we=%0b pend=%h want 0/0", rf_we, pend_mask);
        end
        cyc();
        n_cmp++;
        if (rf_we !== 0) begin
            n_bad++; $display("FAIL x0_late: we=%0b want 0", rf_we);
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 2; i++) begin
            idle();
            ld_valid = 1; ld_rd = 5'(11 + 2 * i); ld_data = i;
            alu_valid = 1; alu_rd = 5'(12 + 2 * i); alu_data = 32'hE0 + i;
            cyc();
        end
        idle();
        n_cmp++;
        if (alu_ready !== 0) begin
            n_bad++; $display("FAIL rmid_full: rdy=%0b want 0", alu_ready);
        end
        rst = 1;
        cyc();
        rst = 0;
        n_cmp++;
        if (rf_we !== 0 || pend_mask !== 0 || alu_ready !== 1) begin
            n_bad++;
            $display("FAIL rmid_rst: we=%0b pend=%h rdy=%0b want 0/0/1",
                     rf_we, pend_mask, alu_ready);
        end
        for (int i = 0; i < 4; i++) begin
            cyc();
            n_cmp++;
            if (rf_we !== 0) begin
                n_bad++;
                $display("FAIL rmid_ghost%0d: we=%0b wa=%0d want we 0", i, rf_we, rf_wa);
            end
        end
    endtask

    task automatic test_hazard();
        idle();
        ld_valid = 1; ld_rd = 2; ld_data = 32'h22;
        alu_valid = 1; alu_rd = 9; alu_data = 32'h99;
        cyc();
        idle();
        n_cmp++;
        if (ovf_err !== 0) begin
            n_bad++; $display("FAIL haz_early: ovf=%0b want 0", ovf_err);
        end
        ld_valid = 1; ld_rd = 9; ld_data = 32'h5;
        cyc();
        idle();
        n_cmp++;
        if (ovf_err !== 1 || rf_wa !== 9 || mem_to_reg !== 1) begin
            n_bad++;
            $display("FAIL haz_set: ovf=%0b wa=%0d m2r=%0b want 1/9/1",
                     ovf_err, rf_wa, mem_to_reg);
        end
        cyc();
        n_cmp++;
        if (rf_we !== 1 || rf_wa !== 9 || rf_wd !== 32'h99 || mem_to_reg !== 0) begin
            n_bad++;
            $display("FAIL haz_alu: we=%0b wa=%0d wd=%h m2r=%0b want 1/9/99/0",
                     rf_we, rf_wa, rf_wd, mem_to_reg);
        end
        for (int i = 0; i < 3; i++) cyc();
        n_cmp++;
        if (ovf_err !== 1) begin
            n_bad++; $display("FAIL haz_sticky: ovf=%0b want 1", ovf_err);
        end
        rst = 1;
        cyc();
        rst = 0;
        n_cmp++;
        if (ovf_err !== 0) begin
            n_bad++; $display("FAIL haz_clear: ovf=%0b want 0", ovf_err);
        end
    endtask

    task automatic test_random();
        logic [31:0] exp_pend;
        idle();
        rst = 1;
        cyc();
        for (int c = 0; c < 600; c++) begin
            rst       = ($urandom_range(0, 79) == 0);
            alu_valid = ($urandom_range(0, 99) < 70);
            alu_rd    = 5'($urandom_range(0, 7) == 0 ? 0 : $urandom_range(1, 31));
            alu_data  = $urandom;
            ld_valid  = ($urandom_range(0, 99) < 40);
            ld_rd     = 5'($urandom_range(0, 7) == 0 ? 0 : $urandom_range(1, 31));
            ld_data   = $urandom;
            n_cmp++;
            if (alu_ready !== (q.size() < DEPTH)) begin
                n_bad++;
                $display("FAIL rnd_ready c%0d: got %0b want %0b",
                         c, alu_ready, q.size() < DEPTH);
            end
            cyc();
            exp_pend = pend_model();
            n_cmp++;
            if (rf_we !== m_we || rf_wa !== m_wa || rf_wd !== m_wd || mem_to_reg !== m_m2r) begin
                n_bad++;
                $display("FAIL rnd_out c%0d: we=%0b wa=%0d wd=%h m2r=%0b want %0b/%0d/%h/%0b",
                         c, rf_we, rf_wa, rf_wd, mem_to_reg, m_we, m_wa, m_wd, m_m2r);
            end
            n_cmp++;
            if (pend_mask !== exp_pend || ovf_err !== m_ovf) begin
                n_bad++;
                $display("FAIL rnd_flags c%0d: pend=%h ovf=%0b want %h/%0b",
                         c, pend_mask, ovf_err, exp_pend, m_ovf);
            end
        end
        idle();
    endtask

    initial begin
        idle();
        q.delete();
        m_we = 0; m_wa = 0; m_wd = 0; m_m2r = 0; m_ovf = 0;
        test_reset();
        test_lone_alu();
        test_collision();
        test_backpressure();
        test_x0();
        test_reset_mid();
        test_hazard();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
